// File: rtl/fetch_controller_if.sv
// Bus bundle between the fetch controller, instruction memory and decoder.
// master: the fetch controller side. slave: memory/decoder/redirect source side.
interface fetch_controller_if;

   logic [7:0] instruction_address;
   logic [7:0] instruction_data;
   logic       redirect_valid;
   logic [7:0] redirect_target;
   logic       out_valid;
   logic [7:0] out_instr;
   logic [7:0] out_pc;
   logic       out_ready;
   logic       halted;

   modport master (
      output instruction_address,
      output out_valid,
      output out_instr,
      output out_pc,
      output halted,
      input  instruction_data,
      input  redirect_valid,
      input  redirect_target,
      input  out_ready
   );

   modport slave (
      input  instruction_address,
      input  out_valid,
      input  out_instr,
      input  out_pc,
      input  halted,
      output instruction_data,
      output redirect_valid,
      output redirect_target,
      output out_ready
   );

endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, fetches one byte per cycle from a
// combinational-read instruction memory, buffers {pc, instr} in a DEPTH-entry
// FIFO and presents the head to the decoder over valid/ready.
// A redirect flushes the FIFO and reloads the PC.
// Optional macro FETCH_HALT_DETECT_EN: stop fetching after enqueueing HALT_OPCODE.
module fetch_controller #(
   parameter int unsigned DEPTH       = 2,
   parameter logic [7:0]  HALT_OPCODE = 8'hFF
) (
   input logic                clk,
   input logic                reset,
   fetch_controller_if.master bus_io
);

   localparam int unsigned    PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned    CntW     = PtrW + 1;
   localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

   logic [7:0]      pc_q, pc_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;

   logic [7:0] fifo_pc_q    [DEPTH];
   logic [7:0] fifo_instr_q [DEPTH];

   logic head_valid;
   logic pop;
   logic can_push;
   logic push;
   logic pop_eff;
   logic halted_q;

   // Handshake qualifiers; redirect suppresses both push and pop in its cycle.
   always_comb begin
      head_valid = (count_q != '0);
      pop        = head_valid & bus_io.out_ready;
      can_push   = ~halted_q & ((count_q < DepthCnt) | pop);
      push       = can_push & ~bus_io.redirect_valid;
      pop_eff    = pop & ~bus_io.redirect_valid;
   end

   // Next-state for PC, FIFO pointers and occupancy.
   always_comb begin
      pc_d     = pc_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (bus_io.redirect_valid) begin
         pc_d     = bus_io.redirect_target;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (pop_eff) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            pc_d     = pc_q + 8'd1;
         end
         unique case ({push, pop_eff})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q     <= 8'h00;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         pc_q     <= pc_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // FIFO storage; contents are masked by head_valid so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc_q[wr_ptr_q]    <= pc_q;
         fifo_instr_q[wr_ptr_q] <= bus_io.instruction_data;
      end
   end

`ifdef FETCH_HALT_DETECT_EN
   logic halted_d;

   // Halt is raised by enqueueing the halt opcode and cleared only by redirect or reset.
   always_comb begin
      halted_d = halted_q;
      if (bus_io.redirect_valid) begin
         halted_d = 1'b0;
      end else if (push && (bus_io.instruction_data == HALT_OPCODE)) begin
         halted_d = 1'b1;
      end
   end

   // Halt flag register.
   always_ff @(posedge clk) begin
      if (reset) begin
         halted_q <= 1'b0;
      end else begin
         halted_q <= halted_d;
      end
   end
`else
   logic unused_halt_opcode;
   assign halted_q           = 1'b0;
   assign unused_halt_opcode = ^HALT_OPCODE;
`endif

   // Outputs are purely register/FIFO derived.
   always_comb begin
      bus_io.instruction_address = pc_q;
      bus_io.out_valid           = head_valid;
      bus_io.out_pc              = head_valid ? fifo_pc_q[rd_ptr_q]    : 8'h00;
      bus_io.out_instr           = head_valid ? fifo_instr_q[rd_ptr_q] : 8'h00;
      bus_io.halted              = halted_q;
   end

   a_count_bounded : assert property (@(posedge clk) disable iff (reset) count_q <= DepthCnt);

endmodule
